uart_rx_deser: RTL



---
 rtl/uart_rx_deser.sv | 102 ++++++++++
 1 files changed

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receiver that turns the serial RX line into a byte plus a one-cycle load strobe.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check (8N1 otherwise).
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);
    localparam logic [15:0] LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [15:0]            cnt;
    logic [2:0]             idx;
    logic [7:0]             shift;
    logic                   par_bad;
    logic                   rxs;
    logic                   tick;
    assign rxs     = sync[SYNC_STAGES-1];
    assign tick    = cnt == LAST;
    assign rx_busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sync       <= '1;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], rx_serial};
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        idx     <= '0;
                        par_bad <= 1'b0;
                        state   <= rxs ? IDLE : DATA;
                    end else cnt <= cnt + 16'd1;
                end
                DATA: begin
                    if (tick) begin
                        cnt        <= '0;
                        shift[idx] <= rxs;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else idx <= idx + 3'd1;
                    end else cnt <= cnt + 16'd1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        cnt     <= '0;
                        par_bad <= rxs ^ (^shift);
                        state   <= STOP;
                    end else cnt <= cnt + 16'd1;
                end
`endif
                STOP: begin
                    if (tick) begin
                        cnt        <= '0;
                        parity_err <= par_bad;
                        // a parity failure withholds the byte even when the stop bit is good
                        if (rxs) begin
                            rx_valid <= !par_bad;
                            if (!par_bad) rx_data <= shift;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else cnt <= cnt + 16'd1;
                end
                BREAK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
